ssd1306_spi_responder: RTL and testbench
========================================

Name: ssd1306_spi_responder

Overview:
Receive-side model of the SSD1306 4-wire SPI link driven by oled_frequency_counter.
- Oversamples SCLK/CSn/DC/MOSI on a local clock and assembles bytes.
- Decodes the command stream and converts data bytes into GDDRAM write strobes with SSD1306 address auto-increment.
- Sits on a second board or in a loopback bench, feeding a frame buffer so transmitted frames can be checked or mirrored.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per SPI input (min 2).
- COLS, 128, display columns; column counter is 7 bits.
- PAGES, 8, display pages; page counter is 3 bits.

Ports:
- clk_in  input  1  oversampling clock; must be at least 4x SPI clock.
- resetn_in  input  1  asynchronous, active-low reset.
- spi_clk_in  input  1  SPI SCLK from master (oled_clk_out); mode 0.
- spi_csn_in  input  1  chip select, active low.
- spi_dc_in  input  1  0 = command byte, 1 = data byte.
- spi_mosi_in  input  1  serial data, MSB first.
- wr_en_out  output  1  one-cycle GDDRAM write strobe.
- wr_addr_out  output  10  page*128 + column.
- wr_data_out  output  8  data byte (bit0 = top pixel row of page).
- display_on_out  output  1  1 after 0xAF, 0 after 0xAE.
- contrast_out  output  8  value from the 0x81 argument.
- addr_mode_out  output  2  0 = horizontal, 1 = vertical, 2 = page.
- cmd_valid_out  output  1  one-cycle pulse per completed command byte (opcode or argument).
- cmd_byte_out  output  8  byte accompanying cmd_valid_out.

Behaviour:
Reset values (async on resetn_in low):
- All strobes 0; wr_addr_out 0; wr_data_out 0; cmd_byte_out 0.
- display_on_out 0; contrast_out 0x7F; addr_mode_out 2.
- col_start 0, col_end 127, page_start 0, page_end 7; col 0, page 0.
- Synchronizers reset to idle levels: sclk 0, csn 1.

Byte capture:
- Rising edge of synchronized SCLK while synced CSn is low shifts MOSI in.
- The 8th edge samples DC and completes the byte.
- CSn high clears the bit counter; a partial byte is discarded.
- Command argument state is kept across CSn toggles, as in SSD1306.
- Latency: wr_en_out / cmd_valid_out assert exactly 1 clk_in cycle after the cycle that detects the 8th edge, and last 1 cycle.

Command FSM, states CMD, ARG1, ARG2:
- 0x20: 1 argument; arg[1:0] becomes the mode. Value 3 is ignored.
- 0x21: 2 arguments. col_start = a1 & 0x7F, col_end = a2 & 0x7F, then col = col_start.
- 0x22: 2 arguments. page_start = a1 & 7, page_end = a2 & 7, then page = page_start.
- 0x81: 1 argument; sets contrast.
- 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: 1 argument each, consumed and ignored.
- 0xAE / 0xAF: display off / on.
- 0xB0–0xB7: page = op & 7.
- 0x00–0x0F: col[3:0] = op[3:0].
- 0x10–0x17: col[6:4] = op[2:0].
- Any other opcode: no arguments, no effect.
- A data byte (DC = 1) arriving in ARG1/ARG2 aborts the pending command: return to CMD, registers unchanged, and the data write still happens.

Data bytes:
- Write at {page, col}, then increment according to mode.
- Horizontal: col++. At col_end, col = col_start and page++; at page_end, page = page_start.
- Vertical: page++. At page_end, page = page_start and col++; at col_end, col = col_start.
- Page: col++ wrapping 127→0; page unchanged.
- col_start > col_end (same for pages): the counter increments to 127 (or 7), wraps to 0, and continues until it reaches the end value.

Edge cases:
- SCLK edges while CSn is high are ignored.
- A CSn rising edge in the same cycle as the 8th SCLK edge discards the byte.
- Reset asserted mid-byte or mid-command returns everything to reset values immediately.

Decomposition:
- ssd1306_pkg holds:
  - opcode localparams;
  - addr_mode_t enum (HORIZ = 0, VERT = 1, PAGE = 2);
  - cmd_state_t enum;
  - function arg_count(opcode) returning 0–2.
- Sub-module spi_byte_receiver (synchronizers, edge detect, shift register, byte_valid/byte/dc outputs). The top holds the FSM and address logic.

Test Plan:
- SPI at clk_in/8: cmd 0xAF then 0x81, 0x40 -> display_on_out = 1; contrast_out = 0x40; three cmd_valid_out pulses carrying 0xAF, 0x81, 0x40.
- Reset defaults, then 0xB3, 0x05, 0x12, then data 0xA5 -> single write, wr_addr_out = 3*128 + 0x25 = 421, wr_data_out = 0xA5.
- 0x20, 0x00; 0x21, 126, 127; 0x22, 6, 7; five data bytes -> addresses 894, 895, 1022, 1023, 894.
- Vertical mode (0x20, 0x01) with default windows; 10 data bytes -> addresses 0, 128, …, 896, then 1, 129.
- CSn raised after 5 bits, then a full byte 0xAF -> only 0xAF is decoded; no spurious byte.
- 0x21, 0x10, then a data byte 0x55 -> FSM returns to CMD, col_start unchanged (0), write at current address with data 0x55; async reset mid-byte -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/ssd1306_pkg.sv
// Shared opcodes, types and helpers for the SSD1306 SPI receive-side model.
package ssd1306_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned PAGE_W = 3;
    localparam int unsigned ADDR_W = PAGE_W + COL_W;

    localparam logic [BYTE_W-1:0] OP_ADDR_MODE   = 8'h20;
    localparam logic [BYTE_W-1:0] OP_COL_ADDR    = 8'h21;
    localparam logic [BYTE_W-1:0] OP_PAGE_ADDR   = 8'h22;
    localparam logic [BYTE_W-1:0] OP_CONTRAST    = 8'h81;
    localparam logic [BYTE_W-1:0] OP_CHARGE_PUMP = 8'h8D;
    localparam logic [BYTE_W-1:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [BYTE_W-1:0] OP_DISP_OFFSET = 8'hD3;
    localparam logic [BYTE_W-1:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [BYTE_W-1:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [BYTE_W-1:0] OP_COM_PINS    = 8'hDA;
    localparam logic [BYTE_W-1:0] OP_VCOMH       = 8'hDB;
    localparam logic [BYTE_W-1:0] OP_DISP_OFF    = 8'hAE;
    localparam logic [BYTE_W-1:0] OP_DISP_ON     = 8'hAF;

    typedef enum logic [1:0] {
        HORIZ = 2'd0,
        VERT  = 2'd1,
        PAGE  = 2'd2
    } addr_mode_t;

    typedef enum logic [1:0] {
        CMD  = 2'd0,
        ARG1 = 2'd1,
        ARG2 = 2'd2
    } cmd_state_t;

    typedef struct packed {
        logic              dc;
        logic [BYTE_W-1:0] data;
    } rx_byte_t;

    // Number of argument bytes following an opcode.
    function automatic logic [1:0] arg_count(input logic [BYTE_W-1:0] op);
        case (op)
            OP_COL_ADDR, OP_PAGE_ADDR:                       return 2'd2;
            OP_ADDR_MODE, OP_CONTRAST, OP_CHARGE_PUMP,
            OP_MUX_RATIO, OP_DISP_OFFSET, OP_CLK_DIV,
            OP_PRECHARGE, OP_COM_PINS, OP_VCOMH:             return 2'd1;
            default:                                         return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_receiver.sv
// Oversampling SPI mode-0 byte receiver: synchronizes SCLK/CSn/DC/MOSI and
// flags a completed byte combinationally in the cycle the 8th rising edge is seen.
module spi_byte_receiver
    import ssd1306_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     spi_clk,
    input  logic     spi_csn,
    input  logic     spi_dc,
    input  logic     spi_mosi,
    output logic     byte_valid_c,
    output rx_byte_t rx_byte_c
);

    localparam int unsigned CNT_W = 3;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic [BYTE_W-2:0]      shift;

    logic sclk_s, csn_s, dc_s, mosi_s, sclk_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;

    assign byte_valid_c = sclk_rise & ~csn_s & (bit_cnt == CNT_W'(7));
    assign rx_byte_c    = '{dc: dc_s, data: {shift, mosi_s}};

    // Synchronizers idle at SCLK low / CSn high; CSn high drops any partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            csn_sync  <= '1;
            dc_sync   <= '0;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_q    <= sclk_s;
            if (csn_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift   <= {shift[BYTE_W-3:0], mosi_s};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_responder.sv
// SSD1306 command decoder and GDDRAM address generator fed by the SPI byte receiver.
module ssd1306_spi_responder
    import ssd1306_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COLS        = 128,
    parameter int unsigned PAGES       = 8
) (
    input  logic              clk_in,
    input  logic              resetn_in,
    input  logic              spi_clk_in,
    input  logic              spi_csn_in,
    input  logic              spi_dc_in,
    input  logic              spi_mosi_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [BYTE_W-1:0] wr_data_out,
    output logic              display_on_out,
    output logic [BYTE_W-1:0] contrast_out,
    output logic [1:0]        addr_mode_out,
    output logic              cmd_valid_out,
    output logic [BYTE_W-1:0] cmd_byte_out
);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

    logic     rx_valid;
    rx_byte_t rx;

    spi_byte_receiver #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk          (clk_in),
        .rst_n        (resetn_in),
        .spi_clk      (spi_clk_in),
        .spi_csn      (spi_csn_in),
        .spi_dc       (spi_dc_in),
        .spi_mosi     (spi_mosi_in),
        .byte_valid_c (rx_valid),
        .rx_byte_c    (rx)
    );

    cmd_state_t        state_q, state_d;
    addr_mode_t        mode_q, mode_d;
    logic [BYTE_W-1:0] op_q, op_d;
    logic [COL_W-1:0]  arg1_q, arg1_d;
    logic [COL_W-1:0]  col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PAGE_W-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic              disp_d;
    logic [BYTE_W-1:0] contrast_d;
    logic              wr_en_d, cmd_valid_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [BYTE_W-1:0] wr_data_d, cmd_byte_d;
    logic [COL_W-1:0]  col_inc;
    logic [PAGE_W-1:0] page_inc;

    assign addr_mode_out = mode_q;

    // Window-aware increments: past the end value they wrap to the start value.
    assign col_inc  = (col_q == col_end_q)   ? col_start_q  : col_q + COL_W'(1);
    assign page_inc = (page_q == page_end_q) ? page_start_q : page_q + PAGE_W'(1);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        op_d         = op_q;
        arg1_d       = arg1_q;
        col_d        = col_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_d       = page_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        disp_d       = display_on_out;
        contrast_d   = contrast_out;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_out;
        wr_data_d    = wr_data_out;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_out;

        if (rx_valid && rx.dc) begin
            // Data byte: write, advance, and abandon any half-received command.
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'({page_q, col_q});
            wr_data_d = rx.data;
            state_d   = CMD;
            case (mode_q)
                HORIZ: begin
                    col_d = col_inc;
                    if (col_q == col_end_q) page_d = page_inc;
                end
                VERT: begin
                    page_d = page_inc;
                    if (page_q == page_end_q) col_d = col_inc;
                end
                default: col_d = col_q + COL_W'(1);
            endcase
        end else if (rx_valid) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = rx.data;
            case (state_q)
                CMD: begin
                    op_d = rx.data;
                    if (arg_count(rx.data) != 2'd0) begin
                        state_d = ARG1;
                    end else begin
                        if (rx.data == OP_DISP_OFF) disp_d = 1'b0;
                        if (rx.data == OP_DISP_ON)  disp_d = 1'b1;
                        if (rx.data[7:3] == 5'b10110) page_d = rx.data[2:0];
                        if (rx.data[7:4] == 4'h0)     col_d[3:0] = rx.data[3:0];
                        if (rx.data[7:3] == 5'b00010) col_d[6:4] = rx.data[2:0];
                    end
                end
                ARG1: begin
                    if (arg_count(op_q) == 2'd2) begin
                        arg1_d  = rx.data[COL_W-1:0];
                        state_d = ARG2;
                    end else begin
                        state_d = CMD;
                        if (op_q == OP_ADDR_MODE && rx.data[1:0] != 2'd3)
                            mode_d = addr_mode_t'(rx.data[1:0]);
                        if (op_q == OP_CONTRAST) contrast_d = rx.data;
                    end
                end
                default: begin
                    state_d = CMD;
                    if (op_q == OP_COL_ADDR) begin
                        col_start_d = arg1_q;
                        col_end_d   = rx.data[COL_W-1:0];
                        col_d       = arg1_q;
                    end
                    if (op_q == OP_PAGE_ADDR) begin
                        page_start_d = arg1_q[PAGE_W-1:0];
                        page_end_d   = rx.data[PAGE_W-1:0];
                        page_d       = arg1_q[PAGE_W-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q        <= CMD;
            mode_q         <= PAGE;
            op_q           <= '0;
            arg1_q         <= '0;
            col_q          <= '0;
            col_start_q    <= '0;
            col_end_q      <= COL_LAST;
            page_q         <= '0;
            page_start_q   <= '0;
            page_end_q     <= PAGE_LAST;
            display_on_out <= 1'b0;
            contrast_out   <= 8'h7F;
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            cmd_valid_out  <= 1'b0;
            cmd_byte_out   <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            op_q           <= op_d;
            arg1_q         <= arg1_d;
            col_q          <= col_d;
            col_start_q    <= col_start_d;
            col_end_q      <= col_end_d;
            page_q         <= page_d;
            page_start_q   <= page_start_d;
            page_end_q     <= page_end_d;
            display_on_out <= disp_d;
            contrast_out   <= contrast_d;
            wr_en_out      <= wr_en_d;
            wr_addr_out    <= wr_addr_d;
            wr_data_out    <= wr_data_d;
            cmd_valid_out  <= cmd_valid_d;
            cmd_byte_out   <= cmd_byte_d;
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_responder.sv
// Scoreboard bench for ssd1306_spi_responder driven by an SPI master at clk_in/8.
module tb_ssd1306_spi_responder;

    logic       clk_in = 1'b0;
    logic       resetn_in = 1'b0;
    logic       spi_clk_in = 1'b0;
    logic       spi_csn_in = 1'b1;
    logic       spi_dc_in = 1'b0;
    logic       spi_mosi_in = 1'b0;
    logic       wr_en_out;
    logic [9:0] wr_addr_out;
    logic [7:0] wr_data_out;
    logic       display_on_out;
    logic [7:0] contrast_out;
    logic [1:0] addr_mode_out;
    logic       cmd_valid_out;
    logic [7:0] cmd_byte_out;

    ssd1306_spi_responder dut (
        .clk_in         (clk_in),
        .resetn_in      (resetn_in),
        .spi_clk_in     (spi_clk_in),
        .spi_csn_in     (spi_csn_in),
        .spi_dc_in      (spi_dc_in),
        .spi_mosi_in    (spi_mosi_in),
        .wr_en_out      (wr_en_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .display_on_out (display_on_out),
        .contrast_out   (contrast_out),
        .addr_mode_out  (addr_mode_out),
        .cmd_valid_out  (cmd_valid_out),
        .cmd_byte_out   (cmd_byte_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit         is_wr;
        logic [7:0] data;
        logic [9:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe cycle pops one expected event.
    always @(negedge clk_in) begin
        if (wr_en_out || cmd_valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event wr=%0b cmd=%0b addr=%0d data=0x%0h cmd_byte=0x%0h",
                         wr_en_out, cmd_valid_out, wr_addr_out, wr_data_out, cmd_byte_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_wr) begin
                    if (!wr_en_out || cmd_valid_out || wr_addr_out !== mon_e.addr || wr_data_out !== mon_e.data) begin
                        failures++;
                        $display("FAIL write actual wr=%0b cmd=%0b addr=%0d data=0x%0h required addr=%0d data=0x%0h",
                                 wr_en_out, cmd_valid_out, wr_addr_out, wr_data_out, mon_e.addr, mon_e.data);
                    end
                end else begin
                    if (!cmd_valid_out || wr_en_out || cmd_byte_out !== mon_e.data) begin
                        failures++;
                        $display("FAIL cmd actual wr=%0b cmd=%0b byte=0x%0h required byte=0x%0h",
                                 wr_en_out, cmd_valid_out, cmd_byte_out, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_dc_in   = dc;
            spi_mosi_in = b[i];
            #40 spi_clk_in = 1'b1;
            #40 spi_clk_in = 1'b0;
        end
    endtask

    task automatic cmd(input logic [7:0] b);
        exp_q.push_back('{is_wr: 1'b0, data: b, addr: 10'd0});
        spi_bits(1'b0, b, 8);
    endtask

    task automatic data(input logic [7:0] b, input logic [9:0] a);
        exp_q.push_back('{is_wr: 1'b1, data: b, addr: a});
        spi_bits(1'b1, b, 8);
    endtask

    task automatic begin_tx();
        @(negedge clk_in);
        spi_csn_in = 1'b0;
        #40;
    endtask

    task automatic end_tx();
        #40 spi_csn_in = 1'b1;
        #80;
    endtask

    task automatic settle(input string name);
        repeat (12) @(negedge clk_in);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        spi_csn_in = 1'b1;
        spi_clk_in = 1'b0;
        resetn_in  = 1'b0;
        repeat (3) @(negedge clk_in);
        resetn_in  = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"},     32'(wr_en_out),      32'd0);
        check({tag, "_wr_addr"},   32'(wr_addr_out),    32'd0);
        check({tag, "_wr_data"},   32'(wr_data_out),    32'd0);
        check({tag, "_cmd_valid"}, 32'(cmd_valid_out),  32'd0);
        check({tag, "_cmd_byte"},  32'(cmd_byte_out),   32'd0);
        check({tag, "_display"},   32'(display_on_out), 32'd0);
        check({tag, "_contrast"},  32'(contrast_out),   32'h7F);
        check({tag, "_mode"},      32'(addr_mode_out),  32'd2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] vaddr [10];
        vaddr = '{10'd0, 10'd128, 10'd256, 10'd384, 10'd512, 10'd640, 10'd768, 10'd896, 10'd1, 10'd129};

        do_reset();
        check_reset_values("reset");

        // Display on, contrast argument, then display off.
        begin_tx();
        cmd(8'hAF); cmd(8'h81); cmd(8'h40);
        end_tx();
        settle("t1");
        check("t1_display", 32'(display_on_out), 32'd1);
        check("t1_contrast", 32'(contrast_out), 32'h40);
        begin_tx(); cmd(8'hAE); end_tx();
        settle("t1b");
        check("t1_display_off", 32'(display_on_out), 32'd0);

        // Page/column opcodes position a single write at 3*128+0x25.
        do_reset();
        begin_tx();
        cmd(8'hB3); cmd(8'h05); cmd(8'h12);
        data(8'hA5, 10'd421);
        end_tx();
        settle("t2");
        check("t2_mode", 32'(addr_mode_out), 32'd2);

        // Horizontal mode in a 2x2 window wraps columns then pages.
        do_reset();
        begin_tx();
        cmd(8'h20); cmd(8'h00);
        cmd(8'h21); cmd(8'd126); cmd(8'd127);
        cmd(8'h22); cmd(8'd6); cmd(8'd7);
        data(8'h01, 10'd894); data(8'h02, 10'd895); data(8'h03, 10'd1022);
        data(8'h04, 10'd1023); data(8'h05, 10'd894);
        end_tx();
        settle("t3");
        check("t3_mode", 32'(addr_mode_out), 32'd0);

        // Vertical mode with full windows walks pages then steps the column.
        do_reset();
        begin_tx();
        cmd(8'h20); cmd(8'h01);
        for (int i = 0; i < 10; i++) data(8'(8'h30 + i), vaddr[i]);
        end_tx();
        settle("t4");
        check("t4_mode", 32'(addr_mode_out), 32'd1);

        // Mode value 3 is ignored.
        begin_tx(); cmd(8'h20); cmd(8'h03); end_tx();
        settle("t4b");
        check("t4_mode3_ignored", 32'(addr_mode_out), 32'd1);

        // Partial byte discarded by CSn, then a clean 0xAF.
        do_reset();
        begin_tx();
        spi_bits(1'b0, 8'hFF, 5);
        end_tx();
        begin_tx(); cmd(8'hAF); end_tx();
        settle("t5");
        check("t5_display", 32'(display_on_out), 32'd1);

        // Data byte aborts a pending 0x21; the next opcode decodes normally.
        do_reset();
        begin_tx();
        cmd(8'h21); cmd(8'h10);
        data(8'h55, 10'd0);
        cmd(8'hAF);
        cmd(8'h81); cmd(8'h22);
        data(8'h66, 10'd1);
        end_tx();
        settle("t6");
        check("t6_display", 32'(display_on_out), 32'd1);
        check("t6_contrast", 32'(contrast_out), 32'h22);

        // Asynchronous reset mid-byte clears outputs within the same cycle.
        begin_tx();
        spi_bits(1'b0, 8'hAE, 3);
        #3 resetn_in = 1'b0;
        #1 check_reset_values("async_reset");
        spi_csn_in = 1'b1;
        repeat (3) @(negedge clk_in);
        resetn_in = 1'b1;
        settle("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
